// File: rtl/ltc2333_sweep_scheduler.sv
// ltc2333_sweep_scheduler
//
// Schedules conversions for the LTC2333. A start command begins a run. Each
// sample period the block sweeps the enabled channels once, from the lowest
// channel to the highest. The run lasts a programmed number of sweeps, or
// until it is aborted. Each conversion produces one SoftSpan configuration
// word for the write engine, handed over on a valid/ready handshake.
//
// Ports:
//   clk              IP clock; all logic on the rising edge
//   reset            synchronous, active-high reset
//   start            one-cycle pulse; begins a run from IDLE
//   abort            one-cycle pulse; ends a run immediately (beats start)
//   active_channels  channel enable mask, bit i enables channel i
//   range            SoftSpan code applied to every channel
//   sample_period    sweep period in clk cycles (0 is treated as 1)
//   n_reads          number of sweeps, 0 = run until aborted
//   cmd_valid        configuration word valid
//   cmd_ready        write engine accepts the word
//   cmd_word         {1'b1, 1'b0, chan[2:0], range[2:0]}
//   cmd_last         word is the last enabled channel of this sweep
//   running          high whenever the scheduler is not IDLE
//   done             one-cycle pulse when a finite run completes
//   overrun          sticky; a period tick arrived mid-sweep
//   sweep_count      sweeps completed in the current or most recent run
module ltc2333_sweep_scheduler #(
  parameter int N_CH     = 8,
  parameter int PERIOD_W = 32,
  parameter int NREADS_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [N_CH-1:0]     active_channels,
  input  logic [2:0]          range,
  input  logic [PERIOD_W-1:0] sample_period,
  input  logic [NREADS_W-1:0] n_reads,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [7:0]          cmd_word,
  output logic                cmd_last,
  output logic                running,
  output logic                done,
  output logic                overrun,
  output logic [NREADS_W-1:0] sweep_count
);

  typedef enum logic [1:0] {IDLE, SWEEP, WAIT} state_t;

  state_t              state, state_nxt;
  logic [N_CH-1:0]     mask_q;
  logic [2:0]          range_q;
  logic [NREADS_W-1:0] n_reads_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_cnt, period_cnt_nxt;
  logic [2:0]          chan_ptr, chan_ptr_nxt;
  logic                pending, pending_nxt;
  logic                overrun_nxt, done_nxt, latch_en;
  logic [NREADS_W-1:0] count_nxt, count_inc;

  logic [2:0] start_ch, first_ch, higher_ch;
  logic       higher_found;
  logic       tick, hs, last_hs;

  // Channel search. start_ch is the lowest set bit of the incoming mask and
  // is used on the starting edge. first_ch is the lowest set bit of the
  // latched mask and is used to restart a sweep. higher_ch is the next
  // enabled channel above the pointer; when there is none, the current word
  // is the last one of the sweep.
  always_comb begin
    start_ch     = '0;
    first_ch     = '0;
    higher_ch    = '0;
    higher_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (active_channels[i]) start_ch = 3'(i);
      if (mask_q[i]) first_ch = 3'(i);
      if (mask_q[i] && (i > int'(chan_ptr))) begin
        higher_ch    = 3'(i);
        higher_found = 1'b1;
      end
    end
  end

  assign running   = (state != IDLE);
  assign cmd_valid = (state == SWEEP);
  assign cmd_word  = cmd_valid ? {1'b1, 1'b0, chan_ptr, range_q} : 8'h00;
  assign cmd_last  = cmd_valid && !higher_found;

  assign tick      = running && (period_cnt == period_q - PERIOD_W'(1));
  assign hs        = cmd_valid && cmd_ready;
  assign last_hs   = hs && !higher_found;
  assign count_inc = (&sweep_count) ? sweep_count : sweep_count + NREADS_W'(1);

  // Next-state logic. A tick that lands on the final handshake of a sweep
  // starts the next sweep directly and is not an overrun. Only a tick seen
  // earlier in the sweep is an overrun; that tick sets the single pending
  // flag. Abort is applied last so that it overrides start, a handshake and
  // a tick arriving in the same cycle, and it leaves overrun and
  // sweep_count at their current values.
  always_comb begin
    state_nxt      = state;
    chan_ptr_nxt   = chan_ptr;
    pending_nxt    = pending;
    overrun_nxt    = overrun;
    count_nxt      = sweep_count;
    done_nxt       = 1'b0;
    latch_en       = 1'b0;
    period_cnt_nxt = tick ? '0 : period_cnt + PERIOD_W'(1);

    case (state)
      IDLE: begin
        period_cnt_nxt = '0;
        if (start && !abort && (|active_channels)) begin
          state_nxt    = SWEEP;
          chan_ptr_nxt = start_ch;
          count_nxt    = '0;
          overrun_nxt  = 1'b0;
          pending_nxt  = 1'b0;
          latch_en     = 1'b1;
        end
      end
      SWEEP: begin
        if (tick && !last_hs) begin
          overrun_nxt = 1'b1;
          pending_nxt = 1'b1;
        end
        if (hs) begin
          if (higher_found) begin
            chan_ptr_nxt = higher_ch;
          end else begin
            count_nxt = count_inc;
            if ((n_reads_q != '0) && (count_inc == n_reads_q)) begin
              state_nxt   = IDLE;
              done_nxt    = 1'b1;
              pending_nxt = 1'b0;
            end else if (pending || tick) begin
              chan_ptr_nxt = first_ch;
              pending_nxt  = 1'b0;
            end else begin
              state_nxt = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (tick) begin
          state_nxt    = SWEEP;
          chan_ptr_nxt = first_ch;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (abort) begin
      state_nxt   = IDLE;
      done_nxt    = 1'b0;
      pending_nxt = 1'b0;
      overrun_nxt = overrun;
      count_nxt   = sweep_count;
    end

    if (state_nxt == IDLE) period_cnt_nxt = '0;
  end

  // State register. The configuration is captured only on an accepted
  // start, so input changes during a run do not affect the word sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      chan_ptr    <= '0;
      period_cnt  <= '0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      done        <= 1'b0;
      sweep_count <= '0;
      mask_q      <= '0;
      range_q     <= '0;
      n_reads_q   <= '0;
      period_q    <= PERIOD_W'(1);
    end else begin
      state       <= state_nxt;
      chan_ptr    <= chan_ptr_nxt;
      period_cnt  <= period_cnt_nxt;
      pending     <= pending_nxt;
      overrun     <= overrun_nxt;
      done        <= done_nxt;
      sweep_count <= count_nxt;
      if (latch_en) begin
        mask_q    <= active_channels;
        range_q   <= range;
        n_reads_q <= n_reads;
        period_q  <= (sample_period == '0) ? PERIOD_W'(1) : sample_period;
      end
    end
  end

endmodule

// File: tb/tb_ltc2333_sweep_scheduler.sv
// tb_ltc2333_sweep_scheduler
//
// Self-checking bench for ltc2333_sweep_scheduler. A reference model works
// out the expected word sequence and the sweep start times. The model does
// this from the period-tick arithmetic, so ticks fall at t + j*period for a
// start sampled at cycle t. Outputs are sampled on the falling edge.
module tb_ltc2333_sweep_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  active_channels;
  logic [2:0]  range;
  logic [31:0] sample_period;
  logic [15:0] n_reads;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_word;
  logic        cmd_last;
  logic        running;
  logic        done;
  logic        overrun;
  logic [15:0] sweep_count;

  int checks = 0;
  int errors = 0;

  ltc2333_sweep_scheduler #(.N_CH(8), .PERIOD_W(32), .NREADS_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .active_channels (active_channels),
    .range           (range),
    .sample_period   (sample_period),
    .n_reads         (n_reads),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_word        (cmd_word),
    .cmd_last        (cmd_last),
    .running         (running),
    .done            (done),
    .overrun         (overrun),
    .sweep_count     (sweep_count)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // True when some tick j*p (j >= 1) falls within cycles [a, b]
  function automatic bit ticksBetween(input int a, input int b, input int p);
    return (b / p) >= ((a + p - 1) / p);
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_running"}, running, 0);
    checkOutput({tag, "_valid"}, cmd_valid, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  // Runs one scheduler session and checks it against the model.
  //   rmode: 0 ready always high, 1 ready one cycle in three, 2 random
  //   abort_at: relative cycle to pulse abort (0 = never)
  //   scramble: randomise the config inputs every cycle after start
  task automatic applyStimulus(input logic [7:0] m, input logic [2:0] rg,
                               input int unsigned per, input int unsigned nr,
                               input int rmode, input int abort_at,
                               input int max_cyc, input bit scramble);
    int  chans[$];
    int  p, c, idx, k, s, e, nxt;
    bit  active, fin, ovr, exp_valid, r, hs, tk, is_last;
    logic [7:0] exp_word;
    logic [2:0] ch3;

    for (int i = 0; i < 8; i++) if (m[i]) chans.push_back(i);
    p = (per == 0) ? 1 : int'(per);

    @(negedge clk);
    active_channels = m;
    range           = rg;
    sample_period   = per;
    n_reads         = 16'(nr);
    cmd_ready       = 1'b0;
    start           = 1'b1;
    @(negedge clk);
    start = 1'b0;

    c = 1; nxt = 1; s = 1; idx = 0; k = 0;
    active = 1'b1; fin = 1'b0; ovr = 1'b0;

    while (c <= max_cyc) begin
      exp_valid = active && (c >= nxt);
      is_last   = (idx == chans.size() - 1);
      checkOutput("running", running, 1);
      checkOutput("valid", cmd_valid, exp_valid);
      checkOutput("done_low", done, 0);
      checkOutput("overrun", overrun, ovr);
      if (exp_valid) begin
        ch3      = 3'(chans[idx]);
        exp_word = {1'b1, 1'b0, ch3, rg};
        checkOutput("word", cmd_word, exp_word);
        checkOutput("last", cmd_last, is_last);
      end

      case (rmode)
        0:       r = 1'b1;
        1:       r = ((c % 3) == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      cmd_ready = r;

      if (abort_at == c) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_running", running, 0);
        checkOutput("abort_valid", cmd_valid, 0);
        checkOutput("abort_count", sweep_count, k);
        checkOutput("abort_overrun", overrun, ovr);
        checkOutput("abort_done", done, 0);
        return;
      end

      if (scramble) begin
        active_channels = 8'($urandom);
        range           = 3'($urandom);
        sample_period   = $urandom;
        n_reads         = 16'($urandom);
      end

      hs = exp_valid && r;
      tk = ((c % p) == 0);
      if (exp_valid && tk && !(hs && is_last)) ovr = 1'b1;
      if (hs) begin
        if (is_last) begin
          if (k != 16'hFFFF) k++;
          e = c;
          if ((nr != 0) && (k == int'(nr))) begin
            fin = 1'b1;
          end else begin
            nxt = ticksBetween(s, e, p) ? e + 1 : ((e / p) + 1) * p + 1;
            s   = nxt;
            idx = 0;
          end
        end else begin
          idx++;
        end
      end

      @(negedge clk);
      c++;
      if (fin) begin
        checkOutput("done_pulse", done, 1);
        checkOutput("done_running", running, 0);
        checkOutput("done_valid", cmd_valid, 0);
        checkOutput("done_count", sweep_count, k);
        checkOutput("done_overrun", overrun, ovr);
        @(negedge clk);
        checkOutput("done_once", done, 0);
        return;
      end
    end
    checkOutput("run_timeout_done", done, 1);
  endtask

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    abort           = 1'b0;
    active_channels = '0;
    range           = '0;
    sample_period   = '0;
    n_reads         = '0;
    cmd_ready       = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", cmd_valid, 0);
    checkOutput("rst_word", cmd_word, 0);
    checkOutput("rst_last", cmd_last, 0);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_count", sweep_count, 0);
    reset = 1'b0;

    // Directed sessions
    applyStimulus(8'hA5, 3'b011, 20, 3, 0, 0, 200, 1'b0);
    applyStimulus(8'h01, 3'b101, 1, 4, 0, 0, 50, 1'b0);
    applyStimulus(8'hFF, 3'b010, 4, 3, 1, 0, 300, 1'b0);
    applyStimulus(8'h10, 3'b111, 10, 0, 0, 1105, 1200, 1'b0);
    applyStimulus(8'h5A, 3'b001, 0, 2, 2, 0, 100, 1'b0);
    applyStimulus(8'hC3, 3'b110, 6, 3, 2, 9, 200, 1'b1);

    // Randomised sessions with the config inputs scrambled mid-run
    for (int n = 0; n < 8; n++) begin
      logic [7:0] rm;
      rm = 8'($urandom_range(1, 255));
      applyStimulus(rm, 3'($urandom), $urandom_range(0, 30),
                    $urandom_range(1, 5), $urandom_range(0, 2), 0, 1500, 1'b1);
    end

    // start with an empty mask is ignored
    @(negedge clk);
    active_channels = 8'h00;
    start           = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkIdleOutputs("empty_mask");
    @(negedge clk);
    checkIdleOutputs("empty_mask2");

    // start and abort together: abort wins
    active_channels = 8'h0F;
    start           = 1'b1;
    abort           = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkIdleOutputs("start_abort");

    // Reset mid-sweep with a word waiting on the handshake
    cmd_ready     = 1'b0;
    sample_period = 32'd50;
    n_reads       = 16'd5;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_valid", cmd_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_rst_valid", cmd_valid, 0);
    checkOutput("mid_rst_word", cmd_word, 0);
    checkOutput("mid_rst_last", cmd_last, 0);
    checkOutput("mid_rst_running", running, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_overrun", overrun, 0);
    checkOutput("mid_rst_count", sweep_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
